// File: rtl/mdu_iterative_if.sv
// Handshake and operand/result bus between the execute stage and the iterative MDU.
interface mdu_iterative_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_in;
  logic            flush_in;
  logic [2:0]      funct3_in;
  logic [XLEN-1:0] rs1_in;
  logic [XLEN-1:0] op_b_in;
  logic            busy_out;
  logic            done_out;
  logic [XLEN-1:0] result_out;

  modport master (
    output start_in, flush_in, funct3_in, rs1_in, op_b_in,
    input  busy_out, done_out, result_out
  );

  modport slave (
    input  start_in, flush_in, funct3_in, rs1_in, op_b_in,
    output busy_out, done_out, result_out
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per clock, sign fix-up in a final cycle.
module mdu_iterative #(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  mdu_iterative_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [2:0]      op;
  logic            neg;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   acc;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opnd;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            done;

  logic load, run, fix;

  // Operand decode at launch: signedness per funct3 and unsigned magnitudes.
  logic            in_div;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_by_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    in_div      = bus.funct3_in[2];
    sign_a      = bus.rs1_in[XLEN-1] &&
                  !(bus.funct3_in == 3'b011 || bus.funct3_in == 3'b101 || bus.funct3_in == 3'b111);
    sign_b      = bus.op_b_in[XLEN-1] &&
                  (bus.funct3_in == 3'b000 || bus.funct3_in == 3'b001 ||
                   bus.funct3_in == 3'b100 || bus.funct3_in == 3'b110);
    abs_a       = sign_a ? XLEN'(-bus.rs1_in) : bus.rs1_in;
    abs_b       = sign_b ? XLEN'(-bus.op_b_in) : bus.op_b_in;
    div_by_zero = in_div && (bus.op_b_in == '0);
    div_ovf     = in_div && !bus.funct3_in[0] &&
                  (bus.rs1_in == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b_in == '1);
    special     = div_by_zero || div_ovf;
    special_res = '0;
    if (div_by_zero) begin
      special_res = bus.funct3_in[1] ? bus.rs1_in : '1;
    end else if (div_ovf) begin
      special_res = bus.funct3_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One iteration of the multiply (shift-add) and divide (restoring) datapaths.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   div_sub;
  logic            div_ge;

  always_comb begin
    mul_sum = acc + (lo[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc[XLEN-1:0], lo[XLEN-1]};
    div_ge  = rem_sh >= {1'b0, opnd};
    div_sub = rem_sh - {1'b0, opnd};
  end

  // Sign fix-up and word select for the final result.
  logic [PW-1:0]   prod, prod_fix;
  logic [XLEN-1:0] fix_res;

  always_comb begin
    prod     = {acc[XLEN-1:0], lo};
    prod_fix = neg ? PW'(-prod) : prod;
    fix_res  = '0;
    case (op)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[PW-1:XLEN];
      3'b100, 3'b101:         fix_res = neg ? XLEN'(-lo) : lo;
      default:                fix_res = neg ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
    endcase
  end

  // Next-state and per-state datapath enables; flush wins over everything.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    run        = 1'b0;
    fix        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_in) begin
          load       = 1'b1;
          state_next = special ? DONE : RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (cnt == CW'(XLEN - 1)) state_next = FIX;
      end
      FIX: begin
        fix        = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush_in) begin
      state_next = IDLE;
      load       = 1'b0;
      run        = 1'b0;
      fix        = 1'b0;
    end
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Datapath registers: launch latch, iteration, and result capture.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      op     <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      lo     <= '0;
      opnd   <= '0;
      result <= '0;
    end else begin
      if (load) begin
        op   <= bus.funct3_in;
        neg  <= (in_div && bus.funct3_in[1]) ? sign_a : (sign_a ^ sign_b);
        cnt  <= '0;
        acc  <= '0;
        lo   <= in_div ? abs_a : abs_b;
        opnd <= in_div ? abs_b : abs_a;
        if (special) result <= special_res;
      end
      if (run) begin
        cnt <= cnt + CW'(1);
        if (op[2]) begin
          acc <= div_ge ? div_sub : rem_sh;
          lo  <= {lo[XLEN-2:0], div_ge};
        end else begin
          acc <= {1'b0, mul_sum[XLEN:1]};
          lo  <= {mul_sum[0], lo[XLEN-1:1]};
        end
      end
      if (fix) result <= fix_res;
    end
  end

  assign bus.busy_out   = busy;
  assign bus.done_out   = done;
  assign bus.result_out = result;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: vector table, random ops against a
// native-arithmetic model, flush/reset aborts, start-while-busy and back-to-back.
module tb_mdu_iterative;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mdu_iterative_if #(.XLEN(32)) bus ();

  mdu_iterative #(.XLEN(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    r = '0;
    case (f3)
      3'b000: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[31:0];  end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'd0, b};       r = p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b};             r = p[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'($signed(a) / $signed(b));
      end
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'($signed(a) % $signed(b));
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  // Launch one op, track edges until done, check latency, busy span and result.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm, input bit poke);
    int edges;
    int busy_n;
    bit seen;
    int exp_lat;
    logic [31:0] want;
    exp_lat = latency(f3, a, b);
    @(negedge clk);
    check({nm, "_pre_done"}, 32'(bus.done_out), 32'd0);
    check({nm, "_pre_busy"}, 32'(bus.busy_out), 32'd0);
    bus.funct3_in = f3;
    bus.rs1_in    = a;
    bus.op_b_in   = b;
    bus.start_in  = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    edges  = 1;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && edges < 100) begin
      @(negedge clk);
      bus.start_in = 1'b0;
      if (poke && edges == 5) begin
        bus.start_in  = 1'b1;
        bus.funct3_in = 3'b101;
        bus.rs1_in    = $urandom;
        bus.op_b_in   = $urandom;
      end
      if (poke && edges > 5 && edges < 12) begin
        bus.rs1_in  = $urandom;
        bus.op_b_in = $urandom;
      end
      if (bus.busy_out) busy_n++;
      if (bus.done_out) seen = 1'b1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    if (!seen) begin
      checks++;
      errs++;
      $display("FAIL %s_timeout: no done within %0d edges", nm, edges);
      void'(sb.pop_front());
    end else begin
      check({nm, "_lat"}, 32'(edges), 32'(exp_lat));
      check({nm, "_busy"}, 32'(busy_n), 32'(exp_lat));
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL %s_sb: got 0x%08h with scoreboard empty", nm, bus.result_out);
      end else begin
        want = sb.pop_front();
        check({nm, "_res"}, bus.result_out, want);
        last_res = want;
      end
    end
  endtask

  // Launch a multiply, abort at RUN iteration 10 by flush or reset, check aftermath.
  task automatic abort_op(input bit use_rst, input string nm);
    int done_n;
    logic [31:0] want;
    want = use_rst ? 32'd0 : last_res;
    @(negedge clk);
    bus.funct3_in = 3'b000;
    bus.rs1_in    = 32'h1234_5678;
    bus.op_b_in   = 32'h0000_0003;
    bus.start_in  = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start_in = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else bus.flush_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.flush_in = 1'b0;
    check({nm, "_busy"}, 32'(bus.busy_out), 32'd0);
    check({nm, "_done"}, 32'(bus.done_out), 32'd0);
    check({nm, "_res"}, bus.result_out, want);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done_out) done_n++;
    end
    check({nm, "_no_done"}, 32'(done_n), 32'd0);
    check({nm, "_res_held"}, bus.result_out, want);
    last_res = want;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul"};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh"};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu"};
    vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu"};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div"};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem"};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        "divu"};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         "remu"};
    vecs[8]  = '{3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, "divu_by0"};
    vecs[9]  = '{3'b110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, "rem_by0"};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};

    bus.start_in  = 1'b0;
    bus.flush_in  = 1'b0;
    bus.funct3_in = '0;
    bus.rs1_in    = '0;
    bus.op_b_in   = '0;
    last_res      = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(bus.busy_out), 32'd0);
    check("reset_done", 32'(bus.done_out), 32'd0);
    check("reset_res", bus.result_out, 32'd0);

    foreach (vecs[i]) run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm, 1'b0);

    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf", 1'b0);

    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_poke", 1'b1);
    run_op(3'b101, 32'd100, 32'd7, 32'd14, "b2b_divu", 1'b0);

    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) b = -b;
      run_op(f3, a, b, model(f3, a, b), $sformatf("rnd%0d_f%0d", i, f3), 1'b0);
    end

    abort_op(1'b0, "flush");
    abort_op(1'b1, "rst_abort");
    run_op(3'b111, 32'd100, 32'd7, 32'd2, "post_rst", 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
